// File: rtl/popcount_pkg.sv
// Shared sizing helpers and saturating arithmetic for the popcount pipeline.
package popcount_pkg;

    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

    // Words are split into 4-bit chunks; an even width may leave a 2-bit tail chunk.
    function automatic int calc_nchunks(input int width);
        return (width + 3) / 4;
    endfunction

    // Signed add clamped to the range of a dw-bit two's-complement value.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int dw);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (dw - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (dw - 1));
        if (sum > hi) begin
            return hi[31:0];
        end else if (sum < lo) begin
            return lo[31:0];
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational ones count of a 4-bit chunk.
module popcount_chunk
    import popcount_pkg::*;
(
    input  logic [3:0] bits_i,
    output logic [2:0] ones_o
);

    assign ones_o = 3'(bits_i[0]) + 3'(bits_i[1]) + 3'(bits_i[2]) + 3'(bits_i[3]);

endmodule

// File: rtl/popcount_pipe.sv
// Two-stage ones-count pipeline with an optional saturating running-disparity
// accumulator, compiled in when POPCOUNT_DISPARITY_EN is defined.
module popcount_pipe
    import popcount_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DISP_WIDTH = 6
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [calc_cw(WIDTH)-1:0]          out_ones,
    output logic signed [DISP_WIDTH-1:0]       out_disp,
    output logic                               out_valid,
    input  logic                               out_ready,
    input  logic                               disp_clr
);

    localparam int CW  = calc_cw(WIDTH);
    localparam int NCH = calc_nchunks(WIDTH);

    logic [2:0]    chunk_cnt [NCH];
    logic          s1_valid_q, s1_valid_d;
    logic [2:0]    s1_cnt_q [NCH];
    logic [2:0]    s1_cnt_d [NCH];
    logic          s2_valid_q, s2_valid_d;
    logic [CW-1:0] ones_q, ones_d;
    logic [CW-1:0] sum_w;
    logic          s2_free, s2_load, accept;

    for (genvar c = 0; c < NCH; c++) begin : g_chunk
        logic [3:0] bits;
        if (4 * c + 4 <= WIDTH) begin : g_full
            assign bits = in_data[4*c +: 4];
        end else begin : g_tail
            assign bits = {2'b00, in_data[4*c +: 2]};
        end
        popcount_chunk u_chunk (
            .bits_i (bits),
            .ones_o (chunk_cnt[c])
        );
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Stage 2 drains when out_ready, stage 1 moves only into a free or draining
    // stage 2, and input is accepted whenever stage 1 can move or is empty.
    assign s2_free  = !s2_valid_q || out_ready;
    assign s2_load  = s1_valid_q && s2_free;
    assign in_ready = out_ready || !s2_valid_q || !s1_valid_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cnt_d   = s1_cnt_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_cnt_d   = chunk_cnt;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        sum_w = '0;
        for (int i = 0; i < NCH; i++) begin
            sum_w = sum_w + CW'(s1_cnt_q[i]);
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        ones_d     = ones_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            ones_d     = sum_w;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cnt_q   <= '{default: '0};
            s2_valid_q <= 1'b0;
            ones_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cnt_q   <= s1_cnt_d;
            s2_valid_q <= s2_valid_d;
            ones_q     <= ones_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_ones  = ones_q;

`ifdef POPCOUNT_DISPARITY_EN
    logic signed [DISP_WIDTH-1:0] acc_q, acc_d;
    logic signed [DISP_WIDTH-1:0] disp_q, disp_d;
    logic signed [DISP_WIDTH-1:0] acc_next;
    logic signed [31:0]           word_disp;
    logic signed [31:0]           acc_base;

    assign word_disp = 2 * $signed(32'(sum_w)) - WIDTH;
    // A clear that coincides with a load wipes history before the word is added.
    assign acc_base  = disp_clr ? 32'sd0 : 32'(acc_q);
    assign acc_next  = DISP_WIDTH'(sat_add(acc_base, word_disp, DISP_WIDTH));

    always_comb begin
        acc_d  = acc_q;
        disp_d = disp_q;
        if (s2_load) begin
            acc_d  = acc_next;
            disp_d = acc_next;
        end else if (disp_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            disp_q <= '0;
        end else begin
            acc_q  <= acc_d;
            disp_q <= disp_d;
        end
    end

    assign out_disp = disp_q;
`else
    logic unused_disp_clr;
    assign unused_disp_clr = disp_clr;
    assign out_disp        = '0;
`endif

endmodule

// File: doc/popcount_pipe.md
POPCOUNT_PIPE -- requirements
Module: popcount_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width, even, range 2..64.
REQ-002 SHALL have parameter DISP_WIDTH, default 6: signed running-disparity accumulator width, range 4..16.
REQ-003 SHALL have port clk, input, 1: single clock, all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data, input, WIDTH: word to count.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: pipeline accepts a word this cycle.
REQ-008 SHALL have port out_ones, output, CW = $clog2(WIDTH+1): count of ones in the word.
REQ-009 SHALL have port out_disp, output, DISP_WIDTH signed: running disparity including this word.
REQ-010 SHALL have port out_valid, output, 1: out_ones/out_disp valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts output.
REQ-012 SHALL have port disp_clr, input, 1: synchronous clear of the disparity accumulator.

Function
REQ-013 SHALL use a two-stage pipeline. Stage 1 registers per-4-bit-chunk partial counts; an odd trailing chunk of 2 bits is counted alone. Stage 2 registers the chunk sum and disparity.
REQ-014 SHALL accept a word when in_valid && in_ready; the result SHALL appear with out_valid exactly 2 cycles later when never stalled.
REQ-015 SHALL drive in_ready = out_ready || !stage-2-valid || !stage-1-valid, giving full throughput of one word per cycle with no bubbles.
REQ-016 SHALL freeze stage 2 and hold outputs stable while out_valid && !out_ready; stage 1 SHALL advance only into a free or draining stage 2.
REQ-017 SHALL compute word disparity as 2*ones - WIDTH, signed; for WIDTH=8 the range is -8..+8.
REQ-018 SHALL update the accumulator only when a word loads stage 2; the loaded out_disp SHALL equal the previous accumulator plus the word disparity.
REQ-019 SHALL saturate the accumulator at -2^(DISP_WIDTH-1) and 2^(DISP_WIDTH-1)-1, with no wrap-around.
REQ-020 disp_clr alone SHALL zero the accumulator next cycle and SHALL NOT alter out_disp of a word already held in stage 2.
REQ-021 disp_clr coincident with a stage-2 load SHALL set the accumulator and out_disp to that word's disparity only (clear, then add).
REQ-022 SHALL make in_data/in_valid don't-care while in_ready=0; the word is not taken.

Reset
REQ-023 On rst_n low, SHALL immediately clear both stage valids, out_valid=0, out_ones=0, out_disp=0 and the accumulator=0.
REQ-024 Reset mid-stream SHALL discard in-flight words; the first word accepted after release SHALL see accumulator 0.
REQ-025 SHALL drive in_ready=1 during and after reset.

Configuration
REQ-026 Macro POPCOUNT_DISPARITY_EN defined: the disparity accumulator, saturation and disp_clr behaviour are compiled in as above.
REQ-027 Macro POPCOUNT_DISPARITY_EN undefined: no accumulator registers, out_disp is tied to 0, disp_clr is ignored, and count/handshake behaviour is identical.

Structure
REQ-028 SHALL place in package popcount_pkg: the CW and chunk-count derivation functions, and the saturating signed-add function.
REQ-029 SHALL instantiate sub-module popcount_chunk (combinational 4-bit to 3-bit ones count) once per stage-1 chunk; no other sub-modules.

Verification
REQ-030 Default params, in_data=8'hFF then 8'h00 back-to-back, out_ready=1: out_ones=8, out_disp=+8 at cycle 2; out_ones=0, out_disp=0 at cycle 3.
REQ-031 Stream 8'h0F continuously with out_ready=1: in_ready stays 1, out_valid stays 1 from cycle 2, out_ones=4, out_disp stays 0.
REQ-032 Stream 8'hFF x5 with DISP_WIDTH=6: out_disp=8,16,24,31,31 (saturated); then 8'h00 gives out_disp=23.
REQ-033 Backpressure: out_ready=0 for 3 cycles with 3 words sent: outputs hold steady, in_ready drops after 2 words, no word is lost or duplicated, and order is preserved.
REQ-034 disp_clr pulsed with a stage-2 load of 8'h07: out_disp=-2. Then rst_n low mid-stream: out_valid=0 immediately, and the next word 8'h01 gives out_disp=-6.
REQ-035 WIDTH=10, in_data=10'h3FF: out_ones=10 (CW=4) and out_disp=+10. Rebuilt without POPCOUNT_DISPARITY_EN: out_disp=0 and identical counts.
